// File: rtl/wb_mtimer_pkg.sv
// Shared definitions for the Wishbone machine timer: register offsets,
// CTRL field positions, reset constants and bus helper functions.
package wb_mtimer_pkg;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 8;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [4:0] off);
        case (off)
            OFF_MTIME_LO:    return REG_MTIME_LO;
            OFF_MTIME_HI:    return REG_MTIME_HI;
            OFF_MTIMECMP_LO: return REG_MTIMECMP_LO;
            OFF_MTIMECMP_HI: return REG_MTIMECMP_HI;
            OFF_CTRL:        return REG_CTRL;
            default:         return REG_NONE;
        endcase
    endfunction

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_mtimer_prescaler.sv
// Tick generator for mtime: one tick every DIV+1 enabled cycles.
module mtimer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  clear,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] CNT_ONE = 1;

    logic [PRESCALE_W-1:0] cnt;

    assign tick = en && (cnt == div);

    // A clear restarts the period; the tick for this edge still uses the old count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/wb_mtimer.sv
// Wishbone-slave RISC-V machine timer: 64-bit mtime/mtimecmp with a
// registered level interrupt and a prescaled count enable.
module wb_mtimer
    import wb_mtimer_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tmr_addr,
    input  logic [31:0] tmr_dat_w,
    input  logic [3:0]  tmr_sel,
    input  logic        tmr_cyc,
    input  logic        tmr_stb,
    input  logic [2:0]  tmr_cti,
    input  logic [1:0]  tmr_bte,
    input  logic        tmr_we,
    output logic [31:0] tmr_dat_r,
    output logic        tmr_ack,
    output logic        tmr_err,
    output logic        timer_interrupt
);

    // Handshake: a request is taken on an edge with cyc&stb and no ack/err
    // outstanding; exactly one of ack (mapped) or err (unmapped) pulses for
    // one cycle, and read data and write effects land on that same edge.
    logic     req;
    reg_sel_e rsel;
    logic     mapped;

    assign req    = tmr_cyc && tmr_stb && !tmr_ack && !tmr_err;
    assign rsel   = decode_offset(tmr_addr[4:0]);
    assign mapped = (rsel != REG_NONE);

    logic unused_bits;
    assign unused_bits = ^{tmr_addr[31:5], tmr_cti, tmr_bte};

    logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, rd_mtime_lo;

    assign wr_mtime_lo = req && tmr_we && (rsel == REG_MTIME_LO);
    assign wr_mtime_hi = req && tmr_we && (rsel == REG_MTIME_HI);
    assign wr_cmp_lo   = req && tmr_we && (rsel == REG_MTIMECMP_LO);
    assign wr_cmp_hi   = req && tmr_we && (rsel == REG_MTIMECMP_HI);
    assign wr_ctrl     = req && tmr_we && (rsel == REG_CTRL);
    assign rd_mtime_lo = req && !tmr_we && (rsel == REG_MTIME_LO);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [31:0]           hi_shadow;
    logic                  ctrl_en;
    logic [PRESCALE_W-1:0] ctrl_div;
    logic                  tick;

    mtimer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl_en),
        .div  (ctrl_div),
        .clear(wr_ctrl),
        .tick (tick)
    );

    logic [31:0] ctrl_rd;
    logic [31:0] ctrl_new;
    logic [31:0] rdata;

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN_BIT] = ctrl_en;
        ctrl_rd[CTRL_DIV_LSB +: PRESCALE_W] = ctrl_div;
        ctrl_new = merge_bytes(ctrl_rd, tmr_dat_w, tmr_sel);
    end

    always_comb begin
        rdata = '0;
        case (rsel)
            REG_MTIME_LO:    rdata = mtime[31:0];
            REG_MTIME_HI:    rdata = hi_shadow;
            REG_MTIMECMP_LO: rdata = mtimecmp[31:0];
            REG_MTIMECMP_HI: rdata = mtimecmp[63:32];
            REG_CTRL:        rdata = ctrl_rd;
            default:         rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_ack   <= 1'b0;
            tmr_err   <= 1'b0;
            tmr_dat_r <= '0;
        end else begin
            tmr_ack <= req && mapped;
            tmr_err <= req && !mapped;
            if (req) tmr_dat_r <= rdata;
        end
    end

    // A software write to either mtime half wins over the tick on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], tmr_dat_w, tmr_sel);
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], tmr_dat_w, tmr_sel);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp  <= MTIMECMP_RST;
            hi_shadow <= '0;
            ctrl_en   <= 1'b1;
            ctrl_div  <= '0;
        end else begin
            if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], tmr_dat_w, tmr_sel);
            if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], tmr_dat_w, tmr_sel);
            if (rd_mtime_lo) hi_shadow <= mtime[63:32];
            if (wr_ctrl) begin
                ctrl_en  <= ctrl_new[CTRL_EN_BIT];
                ctrl_div <= ctrl_new[CTRL_DIV_LSB +: PRESCALE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_wb_mtimer.sv
// Bench for wb_mtimer: a cycle model of the timer feeds an expected queue
// that is checked on every ack/err, plus per-scenario directed checks.
module tb_wb_mtimer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tmr_addr = '0;
  logic [31:0] tmr_dat_w = '0;
  logic [3:0]  tmr_sel = '0;
  logic        tmr_cyc = 1'b0;
  logic        tmr_stb = 1'b0;
  logic [2:0]  tmr_cti = '0;
  logic [1:0]  tmr_bte = '0;
  logic        tmr_we = 1'b0;
  logic [31:0] tmr_dat_r;
  logic        tmr_ack;
  logic        tmr_err;
  logic        timer_interrupt;

  int checks = 0;
  int errors = 0;

  wb_mtimer #(.PRESCALE_W(8)) dut (
    .clk(clk), .rst(rst), .tmr_addr(tmr_addr), .tmr_dat_w(tmr_dat_w),
    .tmr_sel(tmr_sel), .tmr_cyc(tmr_cyc), .tmr_stb(tmr_stb), .tmr_cti(tmr_cti),
    .tmr_bte(tmr_bte), .tmr_we(tmr_we), .tmr_dat_r(tmr_dat_r), .tmr_ack(tmr_ack),
    .tmr_err(tmr_err), .timer_interrupt(timer_interrupt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // entry: {is_read, is_err, data}
  logic [33:0] exp_q[$];

  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow;
  logic        m_en, m_ack, m_err, m_irq;
  logic [7:0]  m_div, m_cnt;

  logic [4:0] m_off;
  logic       m_acc, m_mapped, m_tick;
  assign m_off    = tmr_addr[4:0];
  assign m_acc    = tmr_cyc && tmr_stb && !m_ack && !m_err;
  assign m_mapped = (m_off == 5'h00) || (m_off == 5'h04) || (m_off == 5'h08) ||
                    (m_off == 5'h0C) || (m_off == 5'h10);
  assign m_tick   = m_en && (m_cnt == m_div);

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? w[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] off);
    case (off)
      5'h00: return m_mtime[31:0];
      5'h04: return m_shadow;
      5'h08: return m_cmp[31:0];
      5'h0C: return m_cmp[63:32];
      5'h10: return {16'h0, m_div, 7'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mtime <= '0; m_cmp <= '1; m_shadow <= '0; m_en <= 1'b1; m_div <= '0;
      m_cnt <= '0; m_ack <= 1'b0; m_err <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_irq <= (m_mtime >= m_cmp);
      m_ack <= m_acc && m_mapped;
      m_err <= m_acc && !m_mapped;
      if (m_acc && tmr_we && m_off == 5'h10) m_cnt <= '0;
      else if (m_en) m_cnt <= m_tick ? 8'd0 : m_cnt + 8'd1;
      if (m_acc && tmr_we && m_off == 5'h00) m_mtime[31:0] <= mrg(m_mtime[31:0], tmr_dat_w, tmr_sel);
      else if (m_acc && tmr_we && m_off == 5'h04) m_mtime[63:32] <= mrg(m_mtime[63:32], tmr_dat_w, tmr_sel);
      else if (m_tick) m_mtime <= m_mtime + 64'd1;
      if (m_acc) begin
        if (!m_mapped) begin
          exp_q.push_back({1'b1, 1'b1, 32'h0});
        end else if (!tmr_we) begin
          exp_q.push_back({1'b1, 1'b0, m_read(m_off)});
          if (m_off == 5'h00) m_shadow <= m_mtime[63:32];
        end else begin
          exp_q.push_back({1'b0, 1'b0, 32'h0});
          if (m_off == 5'h08) m_cmp[31:0] <= mrg(m_cmp[31:0], tmr_dat_w, tmr_sel);
          if (m_off == 5'h0C) m_cmp[63:32] <= mrg(m_cmp[63:32], tmr_dat_w, tmr_sel);
          if (m_off == 5'h10) begin
            if (tmr_sel[0]) m_en <= tmr_dat_w[0];
            if (tmr_sel[1]) m_div <= tmr_dat_w[15:8];
          end
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic        prev_resp = 1'b0;
  logic [33:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (timer_interrupt !== m_irq) begin
        errors++;
        $display("FAIL irq_level t=%0t got=%b exp=%b", $time, timer_interrupt, m_irq);
      end
      if (tmr_ack || tmr_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp t=%0t ack=%b err=%b exp=none", $time, tmr_ack, tmr_err);
        end else begin
          e = exp_q.pop_front();
          if (prev_resp || tmr_err !== e[32] || tmr_ack !== !e[32] || (e[33] && tmr_dat_r !== e[31:0])) begin
            errors++;
            $display("FAIL bus_resp t=%0t ack=%b err=%b dat=%h prev=%b exp_err=%b exp_dat=%h",
                     $time, tmr_ack, tmr_err, tmr_dat_r, prev_resp, e[32], e[31:0]);
          end
        end
      end
      prev_resp = tmr_ack || tmr_err;
    end else begin
      prev_resp = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sel, output logic [31:0] rdata, output logic got_err);
    int n;
    @(negedge clk);
    tmr_cyc = 1'b1; tmr_stb = 1'b1; tmr_we = we;
    tmr_addr = addr; tmr_dat_w = wdata; tmr_sel = sel;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tmr_ack || tmr_err) && n < 20);
    if (!(tmr_ack || tmr_err)) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%h got=no_response exp=ack_or_err", addr);
    end
    rdata = tmr_dat_r;
    got_err = tmr_err;
    tmr_cyc = 1'b0; tmr_stb = 1'b0; tmr_we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic ge;
    bus(1'b1, addr, data, 4'hF, d, ge);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic ge;
    bus(1'b0, addr, 32'h0, 4'hF, data, ge);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tmr_ack !== 1'b0 || tmr_err !== 1'b0 || tmr_dat_r !== 32'h0 || timer_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b_%h_%b exp=00_00000000_0", tmr_ack, tmr_err, tmr_dat_r, timer_interrupt);
    end
    rst = 1'b0;
    repeat (9) @(negedge clk);
    rd(32'h00, d);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL idle_count got=%0d exp=10", d); end
    rd(32'h0C, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_hi_reset got=%h exp=ffffffff", d); end
    checks++;
    if (timer_interrupt !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", timer_interrupt); end
  endtask

  task automatic test_prescale();
    logic [31:0] a, b;
    wr(32'h10, 32'h0000_0301);
    rd(32'h00, a);
    repeat (38) @(negedge clk);
    rd(32'h00, b);
    checks++;
    if (b - a !== 32'd10) begin errors++; $display("FAIL div3_advance got=%0d exp=10", b - a); end
    wr(32'h10, 32'h0000_0300);
    rd(32'h00, a);
    repeat (20) @(negedge clk);
    rd(32'h00, b);
    checks++;
    if (b !== a) begin errors++; $display("FAIL frozen got=%h exp=%h", b, a); end
    wr(32'h10, 32'hFFFF_FFFF);
    rd(32'h10, a);
    checks++;
    if (a !== 32'h0000_FF01) begin errors++; $display("FAIL ctrl_reserved got=%h exp=0000ff01", a); end
    wr(32'h10, 32'h0000_0001);
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    int n;
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h0);
    wr(32'h08, 32'd100);
    wr(32'h0C, 32'h0);
    n = 0;
    while (timer_interrupt !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (timer_interrupt !== 1'b1) begin errors++; $display("FAIL irq_rise_timeout got=0 exp=1"); end
    rd(32'h00, d);
    checks++;
    if (d !== 32'd102) begin errors++; $display("FAIL irq_rise_time got=%0d exp=102", d); end
    wr(32'h08, 32'hFFFF_FFFF);
    checks++;
    if (timer_interrupt !== 1'b1) begin errors++; $display("FAIL irq_fall_early got=%b exp=1", timer_interrupt); end
    @(negedge clk);
    checks++;
    if (timer_interrupt !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", timer_interrupt); end
  endtask

  task automatic test_rollover();
    logic [31:0] lo, hi;
    wr(32'h04, 32'h0);
    wr(32'h00, 32'hFFFF_FFF0);
    repeat (30) @(negedge clk);
    rd(32'h00, lo);
    rd(32'h04, hi);
    checks++;
    if (hi !== 32'h1 || lo >= 32'h40) begin errors++; $display("FAIL rollover got=%h_%h exp=00000001_small", hi, lo); end
    wr(32'h04, 32'h0);
    wr(32'h00, 32'hFFFF_FFF0);
    repeat (8) @(negedge clk);
    rd(32'h00, lo);
    repeat (20) @(negedge clk);
    rd(32'h04, hi);
    checks++;
    if (hi !== 32'h0 || lo !== 32'hFFFF_FFF9) begin errors++; $display("FAIL shadow_atomic got=%h_%h exp=00000000_fffffff9", hi, lo); end
    rd(32'h00, lo);
    rd(32'h04, hi);
    checks++;
    if (hi !== 32'h1) begin errors++; $display("FAIL shadow_recapture got=%h exp=00000001", hi); end
  endtask

  task automatic test_lanes_and_err();
    logic [31:0] d;
    logic ge;
    wr(32'h08, 32'hFFFF_FFFF);
    bus(1'b1, 32'h08, 32'hAABB_CCDD, 4'b0010, d, ge);
    rd(32'h08, d);
    checks++;
    if (d !== 32'hFFFF_CCFF) begin errors++; $display("FAIL byte_lane got=%h exp=ffffccff", d); end
    rd(32'hFFFF_FF08, d);
    checks++;
    if (d !== 32'hFFFF_CCFF) begin errors++; $display("FAIL addr_upper_ignored got=%h exp=ffffccff", d); end
    bus(1'b1, 32'h14, 32'h1234_5678, 4'hF, d, ge);
    checks++;
    if (ge !== 1'b1 || tmr_ack !== 1'b0) begin errors++; $display("FAIL unmapped_err got=err%b_ack%b exp=err1_ack0", ge, tmr_ack); end
    @(negedge clk);
    checks++;
    if (tmr_err !== 1'b0) begin errors++; $display("FAIL err_pulse got=%b exp=0", tmr_err); end
    rd(32'h08, d);
    checks++;
    if (d !== 32'hFFFF_CCFF) begin errors++; $display("FAIL unmapped_no_effect got=%h exp=ffffccff", d); end
    bus(1'b0, 32'h14, 32'h0, 4'hF, d, ge);
    checks++;
    if (ge !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_read got=err%b_%h exp=err1_00000000", ge, d); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    logic seen;
    wr(32'h10, 32'h0000_0201);
    @(negedge clk);
    tmr_cyc = 1'b1; tmr_stb = 1'b1; tmr_we = 1'b1;
    tmr_addr = 32'h0C; tmr_dat_w = 32'h1234_5678; tmr_sel = 4'hF;
    #3 rst = 1'b1;
    @(negedge clk);
    seen = tmr_ack || tmr_err;
    tmr_cyc = 1'b0; tmr_stb = 1'b0; tmr_we = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen || tmr_ack || tmr_err;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_drops_ack got=seen exp=none"); end
    rd(32'h10, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset_ctrl got=%h exp=00000001", d); end
    rd(32'h0C, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi got=%h exp=ffffffff", d); end
    rd(32'h08, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo got=%h exp=ffffffff", d); end
    rd(32'h04, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_shadow got=%h exp=00000000", d); end
    wr(32'h0C, 32'h1234_5678);
    rd(32'h0C, d);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL post_reset_xfer got=%h exp=12345678", d); end
  endtask

  task automatic test_random_lanes();
    logic [31:0] d, w;
    logic [3:0] s;
    logic ge;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      s = 4'($urandom_range(0, 15));
      bus(1'b1, 32'h0C, w, s, d, ge);
      rd(32'h0C, d);
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_interrupt();
    test_rollover();
    test_lanes_and_err();
    test_random_lanes();
    test_reset_mid_transfer();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
